// File: rtl/uart_ctrl_arbiter.sv
// Two-requester round-robin front end for a UART transmitter, plus a one-deep receive
// holding register with interrupt clear handshake and sticky overrun flag.
module uart_ctrl_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FRAME_BITS   = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] DataToTransmit,
  output logic       Transmit,
  input  logic       RxInterrupt,
  input  logic [7:0] ReceivedData,
  input  logic       ParityError,
  output logic       ClearInterrupt,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       tx_busy,
  output logic       last_grant
);

  localparam int unsigned FrameCycles = CLKS_PER_BIT * FRAME_BITS;
  localparam int unsigned CntW        = $clog2(FrameCycles);
  localparam logic [CntW-1:0] CntLoad = CntW'(FrameCycles - 2);

  typedef enum logic [1:0] {TxIdle, TxSend, TxWait} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxClear, RxWaitLow} rx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      dtx_q, dtx_d;
  logic            last_q, last_d;
  logic            grant0, grant1;

  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_perr_q, rx_perr_d;
  logic            rx_ovr_q, rx_ovr_d;
  logic            rx_free;

  // Round-robin: on contention the requester that was not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (tx_state_q == TxIdle && !reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    cnt_d      = cnt_q;
    dtx_d      = dtx_q;
    last_d     = last_q;
    case (tx_state_q)
      TxIdle: begin
        if (grant0 || grant1) begin
          dtx_d      = grant1 ? req1_data : req0_data;
          last_d     = grant1;
          tx_state_d = TxSend;
        end
      end
      TxSend: begin
        cnt_d      = CntLoad;
        tx_state_d = TxWait;
      end
      TxWait: begin
        if (cnt_q == '0) begin
          tx_state_d = TxIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // A byte consumed in the same cycle frees the slot for a new capture.
  assign rx_free = !rx_valid_q || rx_ready;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ovr_d   = rx_ovr_q;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    case (rx_state_q)
      RxIdle: begin
        if (RxInterrupt) begin
          if (rx_free) begin
            rx_valid_d = 1'b1;
            rx_data_d  = ReceivedData;
            rx_perr_d  = ParityError;
          end else begin
            rx_ovr_d = 1'b1;
          end
          rx_state_d = RxClear;
        end
      end
      RxClear:   rx_state_d = RxWaitLow;
      RxWaitLow: if (!RxInterrupt) rx_state_d = RxIdle;
      default:   rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      cnt_q      <= '0;
      dtx_q      <= 8'h00;
      last_q     <= 1'b1;
      rx_state_q <= RxIdle;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_perr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      cnt_q      <= cnt_d;
      dtx_q      <= dtx_d;
      last_q     <= last_d;
      rx_state_q <= rx_state_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign req0_ready     = grant0;
  assign req1_ready     = grant1;
  assign DataToTransmit = dtx_q;
  assign Transmit       = (tx_state_q == TxSend);
  assign tx_busy        = (tx_state_q != TxIdle);
  assign last_grant     = last_q;
  assign ClearInterrupt = (rx_state_q == RxClear);
  assign rx_valid       = rx_valid_q;
  assign rx_data        = rx_data_q;
  assign rx_perr        = rx_perr_q;
  assign rx_overrun     = rx_ovr_q;

endmodule

// File: doc/uart_ctrl_arbiter.md
UART_CTRL_ARBITER -- requirements
Module: uart_ctrl_arbiter

Interface
REQ-001 Parameter: CLKS_PER_BIT, 434, clock cycles per UART bit.
REQ-002 Parameter: FRAME_BITS, 11, bits per frame (start, 8 data, parity, stop).
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 Ports, clock and reset first:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
req0_valid  input  1  requester 0 has a byte to send
req0_data  input  8  requester 0 byte
req0_ready  output  1  requester 0 byte accepted this cycle
req1_valid  input  1  requester 1 has a byte to send
req1_data  input  8  requester 1 byte
req1_ready  output  1  requester 1 byte accepted this cycle
DataToTransmit  output  8  byte to UART transmitter
Transmit  output  1  one-cycle start pulse to UART
RxInterrupt  input  1  UART receive-complete flag
ReceivedData  input  8  UART received byte
ParityError  input  1  UART parity error for ReceivedData
ClearInterrupt  output  1  one-cycle clear pulse to UART
rx_valid  output  1  received byte available
rx_data  output  8  received byte
rx_perr  output  1  parity error for rx_data
rx_ready  input  1  consumer takes rx_data
rx_overrun  output  1  sticky: a received byte was dropped
tx_busy  output  1  frame in progress
last_grant  output  1  index of last served requester

Function
REQ-005 Derived constant FRAME_CYCLES = CLKS_PER_BIT*FRAME_BITS (4774 at defaults).
REQ-006 TX FSM states: TX_IDLE, TX_SEND, TX_WAIT.
REQ-007 TX_IDLE: reqN_ready=1 only for the arbitration winner among valid requesters; transfer = valid&ready in the same cycle; both readys 0 when no valid request.
REQ-008 Arbitration SHALL be round-robin: both valid -> requester not equal to last_grant wins; single valid -> it wins regardless of last_grant.
REQ-009 On transfer at cycle T: DataToTransmit registered with the winner's data, last_grant updated, FSM to TX_SEND at T+1.
REQ-010 TX_SEND: Transmit=1 for exactly one cycle (T+1); counter loaded with FRAME_CYCLES-2; next state TX_WAIT.
REQ-011 TX_WAIT: counter decrements each cycle; at counter 0 next state TX_IDLE; TX_IDLE reached at T+FRAME_CYCLES+1.
REQ-012 tx_busy=1 in TX_SEND and TX_WAIT; both reqN_ready SHALL be 0 while tx_busy=1.
REQ-013 DataToTransmit SHALL hold its value from T+1 until the next transfer.
REQ-014 RX FSM states: RX_IDLE, RX_CLEAR, RX_WAITLOW.
REQ-015 RX_IDLE with RxInterrupt=1: if rx_valid=0, capture ReceivedData/ParityError into rx_data/rx_perr and set rx_valid next cycle; if rx_valid=1, keep old data and set rx_overrun; both cases -> RX_CLEAR.
REQ-016 RX_CLEAR: ClearInterrupt=1 for one cycle; next state RX_WAITLOW.
REQ-017 RX_WAITLOW: remain until RxInterrupt=0, then RX_IDLE; no capture in this state.
REQ-018 rx_valid SHALL clear on the cycle after rx_valid&rx_ready; capture and consume in the same cycle SHALL result in rx_valid=1 with new data.
REQ-019 rx_overrun SHALL remain 1 until reset.
REQ-020 TX and RX FSMs SHALL operate independently and concurrently.

Reset
REQ-021 reset=1 at a rising edge SHALL force: TX_IDLE, RX_IDLE, counter 0, Transmit 0, ClearInterrupt 0, DataToTransmit 8'h00, rx_valid 0, rx_data 8'h00, rx_perr 0, rx_overrun 0, last_grant 1 (req0 wins first), tx_busy 0.
REQ-022 While reset=1, req0_ready and req1_ready SHALL be 0.
REQ-023 Reset mid-frame SHALL abort the wait; first transfer allowed in the first cycle after reset deasserts.

Verification (bench with CLKS_PER_BIT=4, FRAME_CYCLES=44)
REQ-024 req0 8'hA5 valid in idle at cycle T -> req0_ready=1 at T, Transmit=1 at T+1 with DataToTransmit=8'hA5, tx_busy=0 at T+45.
REQ-025 req0 8'h11 and req1 8'h22 both held valid from reset -> order 11, 22, 11, 22; Transmit pulses 45 cycles apart.
REQ-026 RxInterrupt=1 held 10 cycles, ReceivedData=8'h55, ParityError=0 -> rx_valid=1, rx_data=8'h55, single ClearInterrupt pulse, no second capture.
REQ-027 Second RxInterrupt with 8'h66 while rx_valid=1, rx_ready=0 -> rx_data stays 8'h55, rx_overrun=1, ClearInterrupt pulses.
REQ-028 reset=1 at T+20 of a frame -> tx_busy=0, Transmit=0 next cycle; new req1 8'h3C accepted first cycle after reset release.
REQ-029 ParityError=1 with 8'h7E capture -> rx_perr=1 with rx_data=8'h7E, cleared with rx_valid on consume.
